// File: rtl/pokemon_pkg.sv
// Shared types and helpers for the overworld player movement logic.
package pokemon_pkg;

  localparam int unsigned TILE_PX = 16;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    REST1 = 2'd0,
    M1    = 2'd1,
    REST2 = 2'd2,
    M2    = 2'd3
  } anim_frame_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    CHECK = 3'd2,
    WALK  = 3'd3,
    BUMP  = 3'd4
  } step_state_t;

  // Legs are mid-swing during the middle half of a tile.
  function automatic logic mid_stride(input int unsigned pix, input int unsigned tile_px);
    return (pix >= tile_px / 4) && (pix < (3 * tile_px) / 4);
  endfunction

endpackage

// File: rtl/player_step_controller_step_target.sv
// Neighbour tile one step along a direction, flagging moves that leave the map.
module step_target
  import pokemon_pkg::*;
#(
  parameter int unsigned MAP_W = 32,
  parameter int unsigned MAP_H = 32
) (
  input  logic [$clog2(MAP_W)-1:0] tile_x,
  input  logic [$clog2(MAP_H)-1:0] tile_y,
  input  dir_t                     dir,
  output logic [$clog2(MAP_W)-1:0] tgt_x_c,
  output logic [$clog2(MAP_H)-1:0] tgt_y_c,
  output logic                     off_map_c
);

  localparam int unsigned XW = $clog2(MAP_W);
  localparam int unsigned YW = $clog2(MAP_H);

  always_comb begin
    tgt_x_c   = tile_x;
    tgt_y_c   = tile_y;
    off_map_c = 1'b0;
    unique case (dir)
      UP: begin
        off_map_c = (tile_y == '0);
        tgt_y_c   = tile_y - YW'(1);
      end
      RIGHT: begin
        off_map_c = (tile_x == XW'(MAP_W - 1));
        tgt_x_c   = tile_x + XW'(1);
      end
      DOWN: begin
        off_map_c = (tile_y == YW'(MAP_H - 1));
        tgt_y_c   = tile_y + YW'(1);
      end
      LEFT: begin
        off_map_c = (tile_x == '0);
        tgt_x_c   = tile_x - XW'(1);
      end
      default: off_map_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/player_step_controller.sv
// Tile-grid player stepping: turn, collision query, walk and bump phases on frame ticks.
// Optional PLAYER_RUN_EN adds run_key, doubling the speed of a step when held on step entry.
module player_step_controller
  import pokemon_pkg::*;
#(
  parameter int unsigned TILE_PX      = pokemon_pkg::TILE_PX,
  parameter int unsigned PX_PER_FRAME = 1,
  parameter int unsigned TURN_FRAMES  = 4,
  parameter int unsigned BUMP_FRAMES  = 8,
  parameter int unsigned MAP_W        = 32,
  parameter int unsigned MAP_H        = 32,
  parameter int unsigned START_X      = 8,
  parameter int unsigned START_Y      = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_tick,
  input  logic                       key_valid,
  input  logic [1:0]                 key_dir,
`ifdef PLAYER_RUN_EN
  input  logic                       run_key,
`endif
  output logic                       coll_req,
  output logic [$clog2(MAP_W)-1:0]   coll_x,
  output logic [$clog2(MAP_H)-1:0]   coll_y,
  input  logic                       coll_ack,
  input  logic                       coll_blocked,
  output logic                       Character_Moving,
  output logic [1:0]                 Direction,
  output logic [1:0]                 anim_frame,
  output logic [$clog2(MAP_W)-1:0]   tile_x,
  output logic [$clog2(MAP_H)-1:0]   tile_y,
  output logic [$clog2(TILE_PX)-1:0] pix_offset
);

  localparam int unsigned XW      = $clog2(MAP_W);
  localparam int unsigned YW      = $clog2(MAP_H);
  localparam int unsigned PW      = $clog2(TILE_PX);
  localparam int unsigned CNT_MAX = (TURN_FRAMES > BUMP_FRAMES) ? TURN_FRAMES : BUMP_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  step_state_t       state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [XW-1:0]     tile_x_q, tile_x_d;
  logic [YW-1:0]     tile_y_q, tile_y_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic              stride_q, stride_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              coll_req_q, coll_req_d;
  logic [XW-1:0]     coll_x_q, coll_x_d;
  logic [YW-1:0]     coll_y_q, coll_y_d;
  logic              moving_q, moving_d;
  anim_frame_t       anim_q, anim_d;

  logic [XW-1:0]     tgt_x_c;
  logic [YW-1:0]     tgt_y_c;
  logic              off_map_c;
  logic [PW:0]       step_px_c;
  logic [PW:0]       pix_sum_c;
  logic              key_match_c;
  logic              mphase_c;
  logic              bump_phase_c;

  step_target #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_step_target (
    .tile_x    (tile_x_q),
    .tile_y    (tile_y_q),
    .dir       (dir_q),
    .tgt_x_c   (tgt_x_c),
    .tgt_y_c   (tgt_y_c),
    .off_map_c (off_map_c)
  );

`ifdef PLAYER_RUN_EN
  logic run_q, run_d;
  assign step_px_c = run_q ? (PW+1)'(2 * PX_PER_FRAME) : (PW+1)'(PX_PER_FRAME);
`else
  assign step_px_c = (PW+1)'(PX_PER_FRAME);
`endif

  assign pix_sum_c   = (PW+1)'(pix_q) + step_px_c;
  assign key_match_c = key_valid && (dir_t'(key_dir) == dir_q);

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tile_x_d   = tile_x_q;
    tile_y_d   = tile_y_q;
    pix_d      = pix_q;
    stride_d   = stride_q;
    cnt_d      = cnt_q;
    coll_req_d = coll_req_q;
    coll_x_d   = coll_x_q;
    coll_y_d   = coll_y_q;
    moving_d   = 1'b0;
    anim_d     = REST1;
`ifdef PLAYER_RUN_EN
    run_d      = run_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (frame_tick && key_valid) begin
          if (key_match_c) begin
            state_d = CHECK;
          end else begin
            dir_d   = dir_t'(key_dir);
            cnt_d   = CW'(TURN_FRAMES);
            state_d = TURN;
          end
        end
      end

      TURN: begin
        if (frame_tick) begin
          if (key_valid && !key_match_c) begin
            dir_d = dir_t'(key_dir);
            cnt_d = CW'(TURN_FRAMES);
          end else begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
              state_d = key_match_c ? CHECK : IDLE;
            end
          end
        end
      end

      // Query is only raised once per visit; an ack is honoured only while it is raised
      CHECK: begin
        if (!coll_req_q) begin
          if (off_map_c) begin
            state_d = BUMP;
            cnt_d   = '0;
          end else begin
            coll_req_d = 1'b1;
            coll_x_d   = tgt_x_c;
            coll_y_d   = tgt_y_c;
          end
        end else if (coll_ack) begin
          coll_req_d = 1'b0;
          if (coll_blocked) begin
            state_d = BUMP;
            cnt_d   = '0;
          end else begin
            state_d = WALK;
            pix_d   = '0;
`ifdef PLAYER_RUN_EN
            run_d   = run_key;
`endif
          end
        end
      end

      WALK: begin
        if (frame_tick) begin
          if (pix_sum_c >= (PW+1)'(TILE_PX)) begin
            pix_d    = '0;
            tile_x_d = tgt_x_c;
            tile_y_d = tgt_y_c;
            stride_d = ~stride_q;
            state_d  = key_match_c ? CHECK : IDLE;
          end else begin
            pix_d = PW'(pix_sum_c);
          end
        end
      end

      BUMP: begin
        if (frame_tick) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d >= CW'(BUMP_FRAMES)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        coll_req_d = 1'b0;
      end
    endcase

    if (state_d == IDLE) begin
      stride_d = 1'b0;
    end

    moving_d = (state_d == WALK);
    unique case (state_d)
      WALK:    anim_d = anim_frame_t'({stride_d, mphase_c});
      BUMP:    anim_d = anim_frame_t'({1'b0, bump_phase_c});
      default: anim_d = anim_frame_t'({stride_d, 1'b0});
    endcase
  end

  assign mphase_c     = mid_stride(32'(pix_d), TILE_PX);
  assign bump_phase_c = 1'(32'(cnt_d) >> 2);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      dir_q      <= DOWN;
      tile_x_q   <= XW'(START_X);
      tile_y_q   <= YW'(START_Y);
      pix_q      <= '0;
      stride_q   <= 1'b0;
      cnt_q      <= '0;
      coll_req_q <= 1'b0;
      coll_x_q   <= '0;
      coll_y_q   <= '0;
      moving_q   <= 1'b0;
      anim_q     <= REST1;
`ifdef PLAYER_RUN_EN
      run_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tile_x_q   <= tile_x_d;
      tile_y_q   <= tile_y_d;
      pix_q      <= pix_d;
      stride_q   <= stride_d;
      cnt_q      <= cnt_d;
      coll_req_q <= coll_req_d;
      coll_x_q   <= coll_x_d;
      coll_y_q   <= coll_y_d;
      moving_q   <= moving_d;
      anim_q     <= anim_d;
`ifdef PLAYER_RUN_EN
      run_q      <= run_d;
`endif
    end
  end

  assign coll_req         = coll_req_q;
  assign coll_x           = coll_x_q;
  assign coll_y           = coll_y_q;
  assign Character_Moving = moving_q;
  assign Direction        = dir_q;
  assign anim_frame       = anim_q;
  assign tile_x           = tile_x_q;
  assign tile_y           = tile_y_q;
  assign pix_offset       = pix_q;

endmodule

// File: tb/tb_player_step_controller.sv
// Directed bench for player_step_controller with a small collision-map responder.
module tb_player_step_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_dir = 2'd0;
  logic       coll_req;
  logic [4:0] coll_x, coll_y;
  logic       coll_ack;
  logic       coll_blocked;
  logic       Character_Moving;
  logic [1:0] Direction;
  logic [1:0] anim_frame;
  logic [4:0] tile_x, tile_y;
  logic [3:0] pix_offset;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int move_cyc = 0;
  int ack_delay = 3;
  logic blk_cfg = 1'b0;
  logic [4:0] last_cx = '0, last_cy = '0;

  player_step_controller dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_tick       (frame_tick),
    .key_valid        (key_valid),
    .key_dir          (key_dir),
    .coll_req         (coll_req),
    .coll_x           (coll_x),
    .coll_y           (coll_y),
    .coll_ack         (coll_ack),
    .coll_blocked     (coll_blocked),
    .Character_Moving (Character_Moving),
    .Direction        (Direction),
    .anim_frame       (anim_frame),
    .tile_x           (tile_x),
    .tile_y           (tile_y),
    .pix_offset       (pix_offset)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Character_Moving) move_cyc <= move_cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    key_valid = 1'b0;
    frame_tick = 1'b0;
    cyc();
    cyc();
    Reset = 1'b0;
  endtask

  // Map responder: acks each query ack_delay cycles after it appears
  initial begin
    coll_ack = 1'b0;
    coll_blocked = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      if (coll_req) begin
        req_cnt++;
        last_cx = coll_x;
        last_cy = coll_y;
        repeat (ack_delay) begin
          @(posedge Clk);
          #2;
        end
        check_eq("coll_xy_stable", int'({coll_x, coll_y}), int'({last_cx, last_cy}));
        coll_ack = 1'b1;
        coll_blocked = blk_cfg;
        @(posedge Clk);
        #2;
        coll_ack = 1'b0;
        coll_blocked = 1'b0;
      end
    end
  end

  task automatic wait_walk(input string tag);
    int n = 0;
    while (!Character_Moving && n < 300) begin
      frame();
      n++;
    end
    check_eq(tag, int'(Character_Moving), 1);
  endtask

  task automatic wait_req_low(input string tag);
    int n = 0;
    while (coll_req && n < 100) begin
      cyc();
      n++;
    end
    check_eq(tag, int'(coll_req), 0);
  endtask

  // One full 16-pixel step from WALK entry, checking offset and walk-cycle frame
  task automatic run_step(input int stride, input int ex, input int ey);
    for (int i = 1; i <= 16; i++) begin
      frame();
      if (i < 16) begin
        check_eq("step_pix", int'(pix_offset), i);
        check_eq("step_anim", int'(anim_frame), stride * 2 + ((i >= 4 && i < 12) ? 1 : 0));
      end
    end
    check_eq("step_pix_wrap", int'(pix_offset), 0);
    check_eq("step_tile_x", int'(tile_x), ex);
    check_eq("step_tile_y", int'(tile_y), ey);
  endtask

  task automatic walk_steps(input logic [1:0] dir, input int n);
    key_valid = 1'b1;
    key_dir = dir;
    for (int s = 0; s < n; s++) begin
      wait_walk("walk_enter");
      if (s == n - 1) key_valid = 1'b0;
      repeat (16) frame();
    end
    cyc();
  endtask

  initial begin
    int base, mv;
    int bump_exp [8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    // Reset values
    do_reset();
    check_eq("rst_dir", int'(Direction), 2);
    check_eq("rst_tile_x", int'(tile_x), 8);
    check_eq("rst_tile_y", int'(tile_y), 8);
    check_eq("rst_pix", int'(pix_offset), 0);
    check_eq("rst_anim", int'(anim_frame), 0);
    check_eq("rst_req", int'(coll_req), 0);
    check_eq("rst_moving", int'(Character_Moving), 0);

    // 1: walk down two tiles, no turn needed
    ack_delay = 3;
    blk_cfg = 1'b0;
    key_valid = 1'b1;
    key_dir = 2'd2;
    wait_walk("t1_walk");
    check_eq("t1_req_cnt", req_cnt, 1);
    check_eq("t1_req_x", int'(last_cx), 8);
    check_eq("t1_req_y", int'(last_cy), 9);
    check_eq("t1_entry_pix", int'(pix_offset), 0);
    check_eq("t1_entry_anim", int'(anim_frame), 0);
    run_step(0, 8, 9);
    check_eq("t1_check_anim", int'(anim_frame), 2);
    check_eq("t1_check_moving", int'(Character_Moving), 0);
    key_valid = 1'b0;
    wait_walk("t1_walk2");
    check_eq("t1_walk2_anim", int'(anim_frame), 2);
    check_eq("t1_req2_y", int'(last_cy), 10);
    run_step(1, 8, 10);
    check_eq("t1_idle_anim", int'(anim_frame), 0);
    check_eq("t1_idle_moving", int'(Character_Moving), 0);

    // 2: tap right for one frame: turn only
    do_reset();
    blk_cfg = 1'b1;
    ack_delay = 0;
    base = req_cnt;
    mv = move_cyc;
    key_valid = 1'b1;
    key_dir = 2'd1;
    frame();
    key_valid = 1'b0;
    check_eq("t2_dir", int'(Direction), 1);
    repeat (4) frame();
    repeat (3) cyc();
    check_eq("t2_no_req", req_cnt - base, 0);
    check_eq("t2_tile_x", int'(tile_x), 8);
    check_eq("t2_tile_y", int'(tile_y), 8);
    check_eq("t2_never_moving", move_cyc - mv, 0);
    key_valid = 1'b1;
    frame();
    key_valid = 1'b0;
    cyc();
    check_eq("t2_idle_req", int'(coll_req), 1);
    check_eq("t2_req_x", int'(coll_x), 9);
    check_eq("t2_req_y", int'(coll_y), 8);
    wait_req_low("t2_req_drop");
    repeat (10) frame();

    // 3: face up, blocked tile -> bump animation
    do_reset();
    blk_cfg = 1'b1;
    ack_delay = 0;
    base = req_cnt;
    mv = move_cyc;
    key_valid = 1'b1;
    key_dir = 2'd0;
    repeat (4) frame();
    cyc();
    cyc();
    check_eq("t3_turn_no_req", int'(coll_req), 0);
    check_eq("t3_turn_cnt", req_cnt - base, 0);
    frame();
    key_valid = 1'b0;
    check_eq("t3_check_entry_req", int'(coll_req), 0);
    cyc();
    check_eq("t3_req", int'(coll_req), 1);
    check_eq("t3_req_x", int'(coll_x), 8);
    check_eq("t3_req_y", int'(coll_y), 7);
    wait_req_low("t3_req_drop");
    check_eq("t3_bump_anim0", int'(anim_frame), 0);
    for (int i = 0; i < 8; i++) begin
      frame();
      check_eq("t3_bump_anim", int'(anim_frame), bump_exp[i]);
      check_eq("t3_bump_moving", int'(Character_Moving), 0);
    end
    check_eq("t3_tile_x", int'(tile_x), 8);
    check_eq("t3_tile_y", int'(tile_y), 8);
    check_eq("t3_never_moving", move_cyc - mv, 0);

    // 4: walk to (0,5), then push left into the map edge
    do_reset();
    blk_cfg = 1'b0;
    ack_delay = 1;
    walk_steps(2'd3, 8);
    check_eq("t4_edge_x", int'(tile_x), 0);
    walk_steps(2'd0, 3);
    check_eq("t4_pos_x", int'(tile_x), 0);
    check_eq("t4_pos_y", int'(tile_y), 5);
    base = req_cnt;
    mv = move_cyc;
    key_valid = 1'b1;
    key_dir = 2'd3;
    repeat (10) frame();
    check_eq("t4_bump_anim", int'(anim_frame), 1);
    repeat (2) frame();
    key_valid = 1'b0;
    repeat (12) frame();
    check_eq("t4_no_req", req_cnt - base, 0);
    check_eq("t4_never_moving", move_cyc - mv, 0);
    check_eq("t4_tile_x", int'(tile_x), 0);
    check_eq("t4_tile_y", int'(tile_y), 5);
    check_eq("t4_dir", int'(Direction), 3);

    // 5: release mid-step, then reset mid-step
    do_reset();
    ack_delay = 2;
    key_valid = 1'b1;
    key_dir = 2'd2;
    wait_walk("t5_walk");
    repeat (5) frame();
    check_eq("t5_pix5", int'(pix_offset), 5);
    key_valid = 1'b0;
    repeat (11) frame();
    check_eq("t5_tile_y", int'(tile_y), 9);
    check_eq("t5_pix", int'(pix_offset), 0);
    check_eq("t5_anim", int'(anim_frame), 0);
    check_eq("t5_moving", int'(Character_Moving), 0);
    repeat (3) frame();
    check_eq("t5_idle_hold", int'(tile_y), 9);
    key_valid = 1'b1;
    wait_walk("t5_walk2");
    repeat (7) frame();
    check_eq("t5_pix7", int'(pix_offset), 7);
    Reset = 1'b1;
    key_valid = 1'b0;
    cyc();
    check_eq("t5_rst_tile_x", int'(tile_x), 8);
    check_eq("t5_rst_tile_y", int'(tile_y), 8);
    check_eq("t5_rst_pix", int'(pix_offset), 0);
    check_eq("t5_rst_dir", int'(Direction), 2);
    check_eq("t5_rst_moving", int'(Character_Moving), 0);
    Reset = 1'b0;
    cyc();

    // 6: hold key across three tiles with a slow map
    do_reset();
    ack_delay = 10;
    base = req_cnt;
    key_valid = 1'b1;
    key_dir = 2'd2;
    for (int s = 0; s < 3; s++) begin
      wait_walk("t6_walk");
      check_eq("t6_req_y", int'(last_cy), 9 + s);
      if (s == 2) key_valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
        frame();
        check_eq("t6_pix", int'(pix_offset), i % 16);
      end
    end
    cyc();
    check_eq("t6_req_cnt", req_cnt - base, 3);
    check_eq("t6_tile_y", int'(tile_y), 11);
    check_eq("t6_tile_x", int'(tile_x), 8);
    check_eq("t6_idle", int'(Character_Moving), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/player_step_controller.md
Name: player_step_controller

Overview:
Sequences overworld player movement on the 16-px tile grid. It converts held direction keys into turn, collision-check, walk and bump phases, timed by the per-frame tick. It drives Character_Moving, Direction and the walk-cycle frame index consumed by color_mapper, plus tile position and sub-tile pixel offset for the renderer. It queries the map/collision unit through a req/ack handshake before each step.

Parameters:
TILE_PX, 16, pixels per tile; must be a power of 2, 8..32
PX_PER_FRAME, 1, pixels advanced per frame_tick while walking; must divide TILE_PX
TURN_FRAMES, 4, frames spent turning in place before walking
BUMP_FRAMES, 8, frames of bump animation against a blocked or edge tile
MAP_W, 32, map width in tiles
MAP_H, 32, map height in tiles
START_X, 8, reset tile x
START_Y, 8, reset tile y

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (vsync)
key_valid  in  1  level: a direction key is held
key_dir  in  2  0 up, 1 right, 2 down, 3 left
coll_req  out  1  collision query valid
coll_x  out  $clog2(MAP_W)  queried tile x
coll_y  out  $clog2(MAP_H)  queried tile y
coll_ack  in  1  one-cycle query response strobe
coll_blocked  in  1  qualified by coll_ack: target tile impassable
Character_Moving  out  1  high only in WALK
Direction  out  2  facing, same encoding as key_dir
anim_frame  out  2  0 Rest1, 1 M1, 2 Rest2, 3 M2
tile_x  out  $clog2(MAP_W)  current tile
tile_y  out  $clog2(MAP_H)  current tile
pix_offset  out  $clog2(TILE_PX)  pixels travelled toward next tile along Direction

Behaviour:
- Reset values: state IDLE, Direction 2 (down), tile = START_X/START_Y, pix_offset 0, anim_frame 0, stride 0, coll_req 0, Character_Moving 0. Reset mid-operation abandons any walk or query. A pending coll_ack after reset is ignored.
- States: IDLE, TURN, CHECK, WALK, BUMP. All outputs are registered.
- IDLE: evaluate only on frame_tick with key_valid=1.
  - key_dir != Direction: Direction <= key_dir, enter TURN with frame counter = TURN_FRAMES.
  - key_dir == Direction: enter CHECK.
- TURN: decrement on each frame_tick. At 0: go to CHECK if key_valid && key_dir==Direction; otherwise go to IDLE. A key for a different direction during TURN re-turns and reloads the counter.
- CHECK: target = tile + unit vector of Direction.
  - If the target is off-map (x=0 moving left, x=MAP_W-1 moving right, same rule for y), do not assert coll_req; go to BUMP the next cycle.
  - Otherwise assert coll_req with coll_x/coll_y stable until the cycle coll_ack=1. Drop coll_req on the following cycle.
  - blocked -> BUMP; clear -> WALK with pix_offset 0.
  - frame_tick is ignored in CHECK. No timeout.
- WALK: Character_Moving=1. The first advance occurs on the first frame_tick after entry; each frame_tick adds PX_PER_FRAME to pix_offset.
  - When the sum reaches TILE_PX: pix_offset wraps to 0, tile steps by one, stride toggles.
  - In that same cycle: go to CHECK if key_valid && key_dir==Direction, otherwise go to IDLE.
  - Key release or a direction change mid-step is ignored; steps always complete.
- anim_frame = {stride, mphase}. In WALK, mphase = 1 when TILE_PX/4 <= pix_offset < 3*TILE_PX/4. In IDLE, TURN and CHECK, mphase = 0 and stride is held; entering IDLE clears stride.
- BUMP: Character_Moving=0, no tile change. anim_frame toggles between 0 and 1 every 4 frame_ticks. After BUMP_FRAMES ticks, go to IDLE.
- Simultaneous frame_tick and coll_ack in CHECK: only the ack is acted upon.

Optional Feature:
PLAYER_RUN_EN
- Defined: adds input run_key. run_key is sampled on entry to WALK; if high, that step advances 2*PX_PER_FRAME per tick (requires 2*PX_PER_FRAME to divide TILE_PX) and mphase thresholds are unchanged.
- Undefined: no run_key port; constant speed.

Decomposition:
- Package pokemon_pkg:
  - dir_t enum (UP=0, RIGHT, DOWN, LEFT)
  - anim_frame_t enum (REST1, M1, REST2, M2)
  - step_state_t enum (IDLE, TURN, CHECK, WALK, BUMP)
  - TILE_PX constant
- Sub-module step_target: combinational; tile_x, tile_y, dir in -> target x/y plus off_map flag.

Test Plan:
1. Reset, then key_dir=2 held, coll responds clear after 3 cycles -> no TURN. coll_req with (8,9). WALK for 16 ticks. tile_y=9, anim sequence 0,1,0 then stride 2,3,2 on the next step.
2. Facing down, tap key_dir=1 for 1 frame -> Direction=1, TURN 4 ticks, then IDLE. No coll_req; tile unchanged at (8,8).
3. Tile (8,8), dir up, coll_blocked=1 -> BUMP 8 ticks. anim_frame toggles 0/1 every 4 ticks. tile stays (8,8), Character_Moving never high.
4. Tile (0,5) facing left, key held -> BUMP with no coll_req ever asserted.
5. Release key at pix_offset=5 -> walk continues to 16, tile advances, then IDLE with anim_frame=0. Reset asserted at pix_offset=7 on a second step -> next cycle tile (8,8), offset 0, Direction 2.
6. Hold key across 3 tiles with coll_ack delayed 10 cycles -> 3 coll_req pulses, tile +3, pix_offset continuous 0..15 per step.
